uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one UART_Tx serializer between NREQ byte requesters.
- Accepts bytes over per-requester valid/ready handshakes and launches each byte with a single-cycle active-low enable.
- Waits for the serializer's RFN pulse before launching the next byte.
- Sits between multiple byte sources (status reporters, sample streamers) and the single board-level UART_Tx. Adds a post-reset holdoff and an RFN watchdog.

---
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_Tx serializer between NREQ byte sources,
// with a post-reset holdoff and an RFN watchdog.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int CPB     = 1250,
  parameter int HOLDOFF = 12 * CPB,
  parameter int TIMEOUT = 16 * CPB
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [8*NREQ-1:0]        i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_nTx_EN,
  output logic [7:0]               o_tx_data,
  input  logic                     i_RFN,
  output logic                     o_busy,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic                     o_timeout,
  output logic [1:0]               state_dbg
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
  localparam int CW   = $clog2(CMAX);

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] rr_ptr;
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  int            idx;

  // Search ascending from rr_ptr, wrapping mod NREQ; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IW'(idx);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Handshake: a byte transfers on the clock edge where i_req_valid[i] & o_req_ready[i];
  // ready is one-hot, only in IDLE, and never depends on a previous cycle's valid.
  always_comb begin
    o_req_ready = '0;
    if (state == S_IDLE && found) o_req_ready[win] = 1'b1;
  end

  assign o_busy    = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= S_HOLD;
      cnt        <= '0;
      rr_ptr     <= '0;
      o_nTx_EN   <= 1'b1;
      o_tx_data  <= 8'h00;
      o_grant_id <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        S_HOLD: begin
          // RFN ignored here: the unreset UART_Tx may still be finishing a frame.
          if (cnt == CW'(HOLDOFF - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (found) begin
            o_tx_data  <= i_req_data[{win, 3'b000} +: 8];
            o_grant_id <= win;
            rr_ptr     <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            o_nTx_EN   <= 1'b0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          o_nTx_EN <= 1'b1;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (i_RFN) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            cnt       <= '0;
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: timeline reference model, behavioural UART_Tx, byte scoreboard,
// a grant-order vector table and hand-written timeout / reset / forced-RFN sequences.
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int CPB     = 4;
  localparam int HOLDOFF = 48;
  localparam int TIMEOUT = 64;
  localparam int FRAME   = 11 * CPB;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic [NREQ-1:0]   i_req_valid = '0;
  logic [8*NREQ-1:0] i_req_data = '0;
  logic [NREQ-1:0]   o_req_ready;
  logic              o_nTx_EN;
  logic [7:0]        o_tx_data;
  logic              i_RFN = 1'b0;
  logic              o_busy;
  logic [1:0]        o_grant_id;
  logic              o_timeout;
  logic [1:0]        state_dbg;

  uart_tx_sched #(.NREQ(NREQ), .CPB(CPB), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nRST(nRST), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_nTx_EN(o_nTx_EN), .o_tx_data(o_tx_data), .i_RFN(i_RFN),
    .o_busy(o_busy), .o_grant_id(o_grant_id), .o_timeout(o_timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [NREQ-1:0]   valid_drv = '0;
  logic [8*NREQ-1:0] data_drv = '0;
  logic              rst_drv = 1'b0;
  logic              rst_prev = 1'b0;
  logic              rfn_force = 1'b0;
  logic              rfn_kill = 1'b0;
  logic              rfn_pend = 1'b0;
  logic              rfn_now = 1'b0;

  // reference model: timestamps of when the scheduler may accept, launch, time out
  int          free_at = 1 << 30;
  logic        in_flight = 1'b0;
  int          launch_cyc = -1;
  int          to_cyc = -1;
  int          rr_m = 0;
  logic [1:0]  exp_gid = '0;
  logic [7:0]  exp_txd = '0;
  logic        acc_flag = 1'b0;
  logic [7:0]  exp_q[$];

  // behavioural UART_Tx
  logic        u_busy = 1'b0;
  int          u_cnt = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          grant;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  function automatic int winner(int rr, logic [3:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- driver + model + checks, one clock per call ----------------
  task automatic tick();
    int         w;
    logic [3:0] er;
    logic       exp_idle;
    @(negedge clk);
    cyc++;
    if (rst_drv && !rst_prev) free_at = cyc + HOLDOFF;
    rst_prev    = rst_drv;
    nRST        = rst_drv;
    i_req_valid = valid_drv;
    i_req_data  = data_drv;
    rfn_now     = (rfn_pend && !rfn_kill) || rfn_force;
    rfn_pend    = 1'b0;
    i_RFN       = rfn_now;
    #1;
    if (!rst_drv) begin
      in_flight = 1'b0; rr_m = 0; exp_gid = '0; exp_txd = '0;
      to_cyc = -1; free_at = 1 << 30; exp_q.delete();
    end
    exp_idle = rst_drv && !in_flight && (cyc >= free_at);
    w  = winner(rr_m, valid_drv);
    er = '0;
    if (exp_idle && w >= 0) er[w] = 1'b1;
    chk("ready",    32'(o_req_ready), 32'(er));
    chk("nTx_EN",   32'(o_nTx_EN),    32'(!(in_flight && cyc == launch_cyc)));
    chk("busy",     32'(o_busy),      32'(!exp_idle));
    chk("timeout",  32'(o_timeout),   32'(cyc == to_cyc));
    chk("grant_id", 32'(o_grant_id),  32'(exp_gid));
    chk("tx_data",  32'(o_tx_data),   32'(exp_txd));
    // UART_Tx model: latch byte on enable, raise RFN after an 11-bit-time frame
    if (!u_busy && !o_nTx_EN) begin
      u_busy = 1'b1;
      u_cnt  = 0;
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
    end else if (u_busy) begin
      u_cnt++;
      if (u_cnt == FRAME) begin
        u_busy   = 1'b0;
        rfn_pend = 1'b1;
      end
    end
    // model advance across the coming clock edge
    acc_flag = 1'b0;
    if (in_flight && cyc > launch_cyc) begin
      if (rfn_now) begin
        in_flight = 1'b0; free_at = cyc + 1;
      end else if (cyc == launch_cyc + TIMEOUT) begin
        in_flight = 1'b0; free_at = cyc + 1; to_cyc = cyc + 1;
      end
    end
    if (exp_idle && w >= 0) begin
      exp_txd    = data_drv[8*w +: 8];
      exp_gid    = 2'(w);
      exp_q.push_back(exp_txd);
      rr_m       = (w + 1) % NREQ;
      in_flight  = 1'b1;
      launch_cyc = cyc + 1;
      acc_flag   = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [3:0] v, input logic [31:0] d, input int exp_g, input string name);
    logic got;
    got = 1'b0;
    valid_drv = v;
    data_drv  = d;
    for (int n = 0; n < 400 && !got; n++) begin
      tick();
      got = acc_flag;
    end
    chk({name, "_accepted"}, 32'(got), 32'd1);
    valid_drv = '0;
    tick();
    chk({name, "_grant"}, 32'(o_grant_id), 32'(exp_g));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    tbl[0]  = '{4'b1111, 32'h44332211, 0};
    tbl[1]  = '{4'b1111, 32'h44332211, 1};
    tbl[2]  = '{4'b1111, 32'h44332211, 2};
    tbl[3]  = '{4'b1111, 32'h44332211, 3};
    tbl[4]  = '{4'b1111, 32'h44332211, 0};
    tbl[5]  = '{4'b0100, 32'h00A50000, 2};
    tbl[6]  = '{4'b0100, 32'h005A0000, 2};
    tbl[7]  = '{4'b0001, 32'h000000E7, 0};
    tbl[8]  = '{4'b1001, 32'h810000FF, 3};
    tbl[9]  = '{4'b0110, 32'h00C33C00, 1};
    tbl[10] = '{4'b0010, 32'h00009600, 1};
    tbl[11] = '{4'b1010, 32'h7E00BD00, 3};

    // reset held for three clocks; requests already pending
    valid_drv = 4'b1111;
    data_drv  = 32'h44332211;
    repeat (3) tick();
    rst_drv = 1'b1;

    // grant order table: holdoff, round robin, wrap search, back-to-back single requester
    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].valid, tbl[i].data, tbl[i].grant, $sformatf("vec%0d", i));

    // RFN disconnected: watchdog fires, next byte launches normally
    rfn_kill = 1'b1;
    run_txn(4'b0001, 32'h000000C3, 0, "to_launch");
    repeat (TIMEOUT + 6) tick();
    rfn_kill = 1'b0;
    run_txn(4'b1000, 32'h3C000000, 3, "after_to");

    // reset mid-WAIT, RFN forced high through HOLD and an idle stretch
    run_txn(4'b0100, 32'h00990000, 2, "pre_rst");
    repeat (10) tick();
    rst_drv = 1'b0;
    repeat (3) tick();
    rst_drv   = 1'b1;
    rfn_force = 1'b1;
    repeat (HOLDOFF + 12) tick();
    rfn_force = 1'b0;
    run_txn(4'b1111, 32'hDDCCBBAA, 0, "post_rst");

    // randomized traffic; valids may drop before being granted
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) valid_drv = 4'($urandom_range(0, 15));
      data_drv = $urandom();
      tick();
    end
    valid_drv = '0;
    repeat (FRAME + 20) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
